// File: rtl/tree_mac_pkg.sv
// ---------------------------------------------------------------------------
// tree_mac_pkg
// Shared types and helpers for the tree-MAC job scheduler.
//   sched_state_e : scheduler FSM states (FLUSH / IDLE / ISSUE / DRAIN)
//   res_entry_t   : result-FIFO entry layout for the default 8/8/8 widths
//   core_lat()    : pipeline latency of the binary-tree MAC core
// ---------------------------------------------------------------------------
package tree_mac_pkg;

   typedef enum logic [1:0] {
      ST_FLUSH = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DRAIN = 2'd3
   } sched_state_e;

   localparam int RES_DW   = 8;
   localparam int RES_AW_I = 8;
   localparam int RES_AW_K = 8;

   typedef struct packed {
      logic [RES_DW-1:0]   data;
      logic [RES_AW_I-1:0] addr_i;
      logic [RES_AW_K-1:0] addr_k;
   } res_entry_t;

   // Adder-tree depth plus multiplier and output register stages.
   function automatic int core_lat(input int data_length);
      return $clog2(data_length) + 2;
   endfunction

endpackage

// File: rtl/tree_mac_result_fifo.sv
// ---------------------------------------------------------------------------
// tree_mac_result_fifo
// Synchronous FIFO holding core results until the consumer takes them.
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   i_push, i_wdata  write request / entry; accepted when not full, or when
//                    a pop happens in the same cycle
//   i_pop            read request; ignored when empty
//   o_rdata          head entry (valid while !o_empty)
//   o_count          number of stored entries
//   o_full, o_empty  status flags
// ---------------------------------------------------------------------------
module tree_mac_result_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_wdata,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_rdata,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == CW'(0));
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A full FIFO can still take a write when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers and occupancy count; DEPTH is a power of 2 so pointers wrap freely.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= PW'(0);
         r_rd_ptr <= PW'(0);
         r_count  <= CW'(0);
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tree_mac_scheduler.sv
// ---------------------------------------------------------------------------
// tree_mac_scheduler
// Walks one I x K job through the non-stallable tree-MAC core and buffers
// the results. Issue is credit-gated (inflight + fifo_count < FIFO_DEPTH) so
// every result the core returns always has a FIFO slot waiting for it.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   cmd_val/cmd_rdy, cmd_last_*   job command handshake, last row/column index
//   op_addr_*, op_en              operand-memory read (1-cycle latency)
//   core_addr_*, core_val         core inputs, aligned with operand data
//   core_*_out, core_sum          core outputs
//   res_val/res_rdy, res_*        result stream
//   busy, done, err_ovf           job in progress, end-of-job pulse, sticky overflow
// ---------------------------------------------------------------------------
module tree_mac_scheduler
   import tree_mac_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int DATA_LENGTH     = 64,
   parameter int ADDRESS_WIDTH_I = 8,
   parameter int ADDRESS_WIDTH_K = 8,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_val,
   output logic                       cmd_rdy,
   input  logic [ADDRESS_WIDTH_I-1:0] cmd_last_i,
   input  logic [ADDRESS_WIDTH_K-1:0] cmd_last_k,
   output logic [ADDRESS_WIDTH_I-1:0] op_addr_i,
   output logic [ADDRESS_WIDTH_K-1:0] op_addr_k,
   output logic                       op_en,
   output logic [ADDRESS_WIDTH_I-1:0] core_addr_i,
   output logic [ADDRESS_WIDTH_K-1:0] core_addr_k,
   output logic                       core_val,
   input  logic [ADDRESS_WIDTH_I-1:0] core_addr_i_out,
   input  logic [ADDRESS_WIDTH_K-1:0] core_addr_k_out,
   input  logic                       core_val_out,
   input  logic [DATA_WIDTH-1:0]      core_sum,
   output logic                       res_val,
   input  logic                       res_rdy,
   output logic [DATA_WIDTH-1:0]      res_data,
   output logic [ADDRESS_WIDTH_I-1:0] res_addr_i,
   output logic [ADDRESS_WIDTH_K-1:0] res_addr_k,
   output logic                       busy,
   output logic                       done,
   output logic                       err_ovf
);

   localparam int AWI      = ADDRESS_WIDTH_I;
   localparam int AWK      = ADDRESS_WIDTH_K;
   localparam int CORE_LAT = core_lat(DATA_LENGTH);
   localparam int CW       = $clog2(FIFO_DEPTH+1);
   localparam int FW       = $clog2(CORE_LAT+2);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [AWI-1:0]        addr_i;
      logic [AWK-1:0]        addr_k;
   } entry_t;

   sched_state_e   r_state;
   logic [FW-1:0]  r_flush_cnt;
   logic [AWI-1:0] r_last_i, r_idx_i, r_op_addr_i, r_core_addr_i;
   logic [AWK-1:0] r_last_k, r_idx_k, r_op_addr_k, r_core_addr_k;
   logic           r_op_en, r_core_val, r_cmd_rdy, r_busy, r_done, r_err_ovf;
   logic [CW-1:0]  r_inflight;

   entry_t         w_push_entry, w_head;
   logic [CW-1:0]  w_fifo_count;
   logic [CW:0]    w_credit_sum;
   logic           w_fifo_full, w_fifo_empty;
   logic           w_issue, w_ret, w_pop, w_last_issue, w_job_done;

   assign w_credit_sum = {1'b0, r_inflight} + {1'b0, w_fifo_count};
   assign w_issue      = (r_state == ST_ISSUE) && (w_credit_sum < (CW+1)'(FIFO_DEPTH));
   // Valids emerging from the un-resettable core are stale while flushing.
   assign w_ret        = core_val_out && (r_state != ST_FLUSH);
   assign w_pop        = !w_fifo_empty && res_rdy;
   assign w_last_issue = (r_idx_i == r_last_i) && (r_idx_k == r_last_k);
   assign w_job_done   = (r_state == ST_DRAIN) && (r_inflight == CW'(0)) &&
                         (w_fifo_count == CW'(1)) && w_pop;
   assign w_push_entry = '{data: core_sum, addr_i: core_addr_i_out, addr_k: core_addr_k_out};

   tree_mac_result_fifo #(
      .WIDTH (DATA_WIDTH + AWI + AWK),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_ret),
      .i_wdata (w_push_entry),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Scheduler FSM: flush timer, job walk, operand fetch and core-input registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= ST_FLUSH;
         r_flush_cnt   <= FW'(0);
         r_last_i      <= AWI'(0);
         r_last_k      <= AWK'(0);
         r_idx_i       <= AWI'(0);
         r_idx_k       <= AWK'(0);
         r_op_en       <= 1'b0;
         r_op_addr_i   <= AWI'(0);
         r_op_addr_k   <= AWK'(0);
         r_core_val    <= 1'b0;
         r_core_addr_i <= AWI'(0);
         r_core_addr_k <= AWK'(0);
         r_cmd_rdy     <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_done        <= 1'b0;
         r_op_en       <= w_issue;
         // Operand data returns one cycle after op_en; core inputs follow it.
         r_core_val    <= r_op_en;
         r_core_addr_i <= r_op_addr_i;
         r_core_addr_k <= r_op_addr_k;
         if (w_issue) begin
            r_op_addr_i <= r_idx_i;
            r_op_addr_k <= r_idx_k;
         end
         case (r_state)
            ST_FLUSH: begin
               if (r_flush_cnt == FW'(CORE_LAT)) begin
                  r_state   <= ST_IDLE;
                  r_cmd_rdy <= 1'b1;
               end else begin
                  r_flush_cnt <= r_flush_cnt + FW'(1);
               end
            end
            ST_IDLE: begin
               if (cmd_val && r_cmd_rdy) begin
                  r_last_i  <= cmd_last_i;
                  r_last_k  <= cmd_last_k;
                  r_idx_i   <= AWI'(0);
                  r_idx_k   <= AWK'(0);
                  r_state   <= ST_ISSUE;
                  r_cmd_rdy <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (w_issue) begin
                  if (w_last_issue) begin
                     r_state <= ST_DRAIN;
                  end else if (r_idx_k == r_last_k) begin
                     r_idx_k <= AWK'(0);
                     r_idx_i <= r_idx_i + AWI'(1);
                  end else begin
                     r_idx_k <= r_idx_k + AWK'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (w_job_done) begin
                  r_done    <= 1'b1;
                  r_state   <= ST_IDLE;
                  r_cmd_rdy <= 1'b1;
                  r_busy    <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_FLUSH;
               r_flush_cnt <= FW'(0);
               r_cmd_rdy   <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // Inflight credit counter: issues add, core returns subtract.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_inflight <= CW'(0);
      end else begin
         case ({w_issue, w_ret && (r_inflight != CW'(0))})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Sticky overflow flag: a core result found no room in the FIFO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_err_ovf <= 1'b0;
      end else if (w_ret && w_fifo_full && !w_pop) begin
         r_err_ovf <= 1'b1;
      end else begin
         r_err_ovf <= r_err_ovf;
      end
   end

   assign cmd_rdy     = r_cmd_rdy;
   assign op_en       = r_op_en;
   assign op_addr_i   = r_op_addr_i;
   assign op_addr_k   = r_op_addr_k;
   assign core_val    = r_core_val;
   assign core_addr_i = r_core_addr_i;
   assign core_addr_k = r_core_addr_k;
   assign res_val     = !w_fifo_empty;
   assign res_data    = w_head.data;
   assign res_addr_i  = w_head.addr_i;
   assign res_addr_k  = w_head.addr_k;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_tree_mac_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tree_mac_scheduler
// Directed bench: a behavioural operand memory and fixed-latency core model
// feed the scheduler; a table of jobs is applied in a loop and the multi-cycle
// corners (credit stall, held cmd_val, reset mid-job) are hand-written.
// ---------------------------------------------------------------------------
module tb_tree_mac_scheduler;
   import tree_mac_pkg::*;

   localparam int DW  = 8;
   localparam int DL  = 4;
   localparam int AWI = 8;
   localparam int AWK = 8;
   localparam int FD  = 8;
   localparam int CL  = $clog2(DL) + 2;

   logic           clk, reset, cmd_val, cmd_rdy, op_en, core_val, core_val_out;
   logic           res_val, res_rdy, busy, done, err_ovf;
   logic [AWI-1:0] cmd_last_i, op_addr_i, core_addr_i, core_addr_i_out, res_addr_i;
   logic [AWK-1:0] cmd_last_k, op_addr_k, core_addr_k, core_addr_k_out, res_addr_k;
   logic [DW-1:0]  core_sum, res_data;

   int n_vec = 0;
   int n_err = 0;
   logic garbage;

   tree_mac_scheduler #(
      .DATA_WIDTH(DW), .DATA_LENGTH(DL), .ADDRESS_WIDTH_I(AWI),
      .ADDRESS_WIDTH_K(AWK), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
      .cmd_last_i(cmd_last_i), .cmd_last_k(cmd_last_k),
      .op_addr_i(op_addr_i), .op_addr_k(op_addr_k), .op_en(op_en),
      .core_addr_i(core_addr_i), .core_addr_k(core_addr_k), .core_val(core_val),
      .core_addr_i_out(core_addr_i_out), .core_addr_k_out(core_addr_k_out),
      .core_val_out(core_val_out), .core_sum(core_sum),
      .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
      .res_addr_i(res_addr_i), .res_addr_k(res_addr_k),
      .busy(busy), .done(done), .err_ovf(err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the dot product of row i and column k.
   function automatic logic [7:0] model_sum(input int i, input int k);
      int t;
      t = i * 37 + k * 11 + 5;
      return t[7:0];
   endfunction

   // Operand memory (1-cycle read) and a CL-stage core without reset.
   logic [DW-1:0]  mem_q;
   logic [CL-1:0]  pv;
   logic [AWI-1:0] pi [CL];
   logic [AWK-1:0] pk [CL];
   logic [DW-1:0]  ps [CL];
   always @(posedge clk) begin
      if (op_en) mem_q <= model_sum(int'(op_addr_i), int'(op_addr_k));
      pv    <= {pv[CL-2:0], core_val};
      pi[0] <= core_addr_i;
      pk[0] <= core_addr_k;
      ps[0] <= mem_q;
      for (int j = 1; j < CL; j++) begin
         pi[j] <= pi[j-1];
         pk[j] <= pk[j-1];
         ps[j] <= ps[j-1];
      end
   end
   assign core_val_out    = pv[CL-1] | garbage;
   assign core_addr_i_out = garbage ? 8'h5A : pi[CL-1];
   assign core_addr_k_out = garbage ? 8'hC3 : pk[CL-1];
   assign core_sum        = garbage ? 8'hEE : ps[CL-1];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic start_job(input int li, input int lk, input bit hold);
      int w;
      w = 0;
      while (!cmd_rdy && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("cmd_rdy_before_job", cmd_rdy, 1);
      cmd_last_i = AWI'(li);
      cmd_last_k = AWK'(lk);
      cmd_val    = 1'b1;
      @(negedge clk);
      if (!hold) cmd_val = 1'b0;
      chk("busy_after_accept", busy, 1);
   endtask

   // Follows one job to its done pulse, checking every issue and result in order.
   task automatic monitor_job(input int li, input int lk, input int pct, input int iss_start,
                              output int n_res, output int n_iss, output int lat, output bit b2b);
      int cyc, first_iss, first_res, last_iss, last_hs, done_cyc, ii, ik, ri, rk, rdy_bad;
      res_entry_t exp_e;
      n_res = 0; n_iss = 0; lat = -1; b2b = 1'b1;
      first_iss = -1; first_res = -1; last_iss = -1; last_hs = -1; done_cyc = -1; rdy_bad = 0;
      ii = iss_start / (lk + 1); ik = iss_start % (lk + 1); ri = 0; rk = 0; cyc = 0;
      while (done_cyc < 0 && cyc < 6000) begin
         res_rdy = ($urandom_range(99) < pct);
         if (done) done_cyc = cyc;
         else if (cmd_rdy) rdy_bad++;
         if (op_en) begin
            chk("issue_addr", {op_addr_i, op_addr_k}, {AWI'(ii), AWK'(ik)});
            if (last_iss >= 0 && cyc != last_iss + 1) b2b = 1'b0;
            if (first_iss < 0) first_iss = cyc;
            last_iss = cyc;
            n_iss++;
            if (ik == lk) begin ik = 0; ii++; end else ik++;
         end
         if (res_val && first_res < 0) first_res = cyc;
         if (res_val && res_rdy) begin
            exp_e.data   = model_sum(ri, rk);
            exp_e.addr_i = AWI'(ri);
            exp_e.addr_k = AWK'(rk);
            chk("result_entry", {res_data, res_addr_i, res_addr_k}, exp_e);
            n_res++;
            last_hs = cyc;
            if (rk == lk) begin rk = 0; ri++; end else rk++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("job_done_seen", (done_cyc >= 0), 1);
      chk("done_after_last_pop", done_cyc, last_hs + 1);
      chk("cmd_rdy_low_while_busy", rdy_bad, 0);
      chk("err_ovf", err_ovf, 0);
      if (first_iss >= 0 && first_res >= 0) lat = first_res - first_iss;
   endtask

   // Checks the FLUSH window after reset release; garbage core valids stop inside it.
   task automatic flush_check();
      for (int n = 1; n <= CL + 2; n++) begin
         @(negedge clk);
         chk("flush_res_val", res_val, 0);
         chk("flush_cmd_rdy", cmd_rdy, (n >= CL + 1));
         if (n == CL - 1) garbage = 1'b0;
      end
   endtask

   typedef struct {
      int li;
      int lk;
      int pct;
      int exp_n;
      bit chk_b2b;
   } vec_t;

   initial begin
      vec_t vecs [5];
      int   n_res, n_iss, lat, cnt;
      bit   b2b;

      vecs[0] = '{li: 0,  lk: 0,  pct: 100, exp_n: 1,   chk_b2b: 1'b1};
      vecs[1] = '{li: 2,  lk: 3,  pct: 100, exp_n: 12,  chk_b2b: 1'b1};
      vecs[2] = '{li: 15, lk: 15, pct: 30,  exp_n: 256, chk_b2b: 1'b0};
      vecs[3] = '{li: 1,  lk: 4,  pct: 50,  exp_n: 10,  chk_b2b: 1'b0};
      vecs[4] = '{li: 0,  lk: 7,  pct: 100, exp_n: 8,   chk_b2b: 1'b1};

      reset = 1'b0; cmd_val = 1'b0; res_rdy = 1'b0; garbage = 1'b0;
      cmd_last_i = '0; cmd_last_k = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_rdy", cmd_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_val", res_val, 0);
      chk("rst_op_en", op_en, 0);
      chk("rst_core_val", core_val, 0);
      chk("rst_done", done, 0);
      chk("rst_err_ovf", err_ovf, 0);
      reset = 1'b1;
      flush_check();

      for (int v = 0; v < 5; v++) begin
         start_job(vecs[v].li, vecs[v].lk, 1'b0);
         monitor_job(vecs[v].li, vecs[v].lk, vecs[v].pct, 0, n_res, n_iss, lat, b2b);
         chk("n_results", n_res, vecs[v].exp_n);
         chk("n_issues", n_iss, vecs[v].exp_n);
         chk("latency", lat, CL + 2);
         if (vecs[v].chk_b2b) chk("back_to_back", b2b, 1);
      end

      // Credit stall: consumer blocked, exactly FD issues then nothing.
      res_rdy = 1'b0;
      start_job(3, 3, 1'b0);
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (op_en) cnt++;
      end
      chk("stall_issues", cnt, FD);
      chk("stall_res_val", res_val, 1);
      chk("stall_err_ovf", err_ovf, 0);
      monitor_job(3, 3, 100, cnt, n_res, n_iss, lat, b2b);
      chk("stall_n_results", n_res, 16);
      chk("stall_n_issues", n_iss, 16 - FD);

      // cmd_val held through a job: next job only after done, indices restart.
      start_job(1, 1, 1'b1);
      monitor_job(1, 1, 100, 0, n_res, n_iss, lat, b2b);
      chk("hold_job1_results", n_res, 4);
      @(negedge clk);
      chk("hold_job2_accepted", busy, 1);
      cmd_val = 1'b0;
      monitor_job(1, 1, 100, 0, n_res, n_iss, lat, b2b);
      chk("hold_job2_results", n_res, 4);

      // Reset in the middle of ISSUE with garbage core valids.
      start_job(7, 7, 1'b0);
      res_rdy = 1'b1;
      repeat (8) @(negedge clk);
      reset = 1'b0;
      garbage = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_res_val", res_val, 0);
         chk("midrst_busy", busy, 0);
      end
      reset = 1'b1;
      flush_check();
      repeat (4) begin
         @(negedge clk);
         chk("post_flush_res_val", res_val, 0);
      end
      chk("post_flush_err_ovf", err_ovf, 0);
      start_job(2, 2, 1'b0);
      monitor_job(2, 2, 100, 0, n_res, n_iss, lat, b2b);
      chk("post_rst_results", n_res, 9);
      chk("post_rst_latency", lat, CL + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
